perm_engine: RTL



---
 rtl/perm_pkg.sv | 32 +++
 rtl/perm_if.sv | 40 ++++
 rtl/perm_regfile.sv | 56 +++++
 rtl/perm_engine.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
// ============================================================================
// Module : perm_pkg
// Brief  : Shared constants, FSM state type and descending-pattern helper
//          for the permutation engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package perm_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FIND_PIVOT = 3'd1,
    ST_FIND_SUCC  = 3'd2,
    ST_SWAP       = 3'd3,
    ST_REVERSE    = 3'd4,
    ST_WRAP       = 3'd5,
    ST_VALID      = 3'd6
  } perm_state_t;

  // Symbol expected at position k of the fully descending permutation of n symbols.
  function automatic int desc_elem(input int n, input int k);
    return n - 1 - k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/perm_if.sv
// ============================================================================
// Module : perm_if
// Brief  : Step/read handshake between the controller (master) and the
//          permutation engine (slave).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface perm_if #(
  parameter int IDX_W = perm_pkg::IDX_W
) ();

  logic             step;
  logic [IDX_W-1:0] W;
  logic [IDX_W-1:0] perm_val;
  logic             permute_valid;
  logic             busy;
  logic             last;

  modport master (
    output step,
    output W,
    input  perm_val,
    input  permute_valid,
    input  busy,
    input  last
  );

  modport slave (
    input  step,
    input  W,
    output perm_val,
    output permute_valid,
    output busy,
    output last
  );

endinterface

`default_nettype wire

// File: rtl/perm_regfile.sv
// ============================================================================
// Module : perm_regfile
// Brief  : N x IDX_W permutation storage: one read port, two compare ports,
//          a two-address swap write and a synchronous identity load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module perm_regfile
  import perm_pkg::*;
#(
  parameter int N     = perm_pkg::N,
  parameter int IDX_W = perm_pkg::IDX_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load_id,
  input  wire logic             i_swap_en,
  input  wire logic [IDX_W-1:0] i_swap_a,
  input  wire logic [IDX_W-1:0] i_swap_b,
  input  wire logic [IDX_W-1:0] i_rd_addr,
  output logic      [IDX_W-1:0] o_rd_data,
  input  wire logic [IDX_W-1:0] i_cmp_a_addr,
  output logic      [IDX_W-1:0] o_cmp_a_data,
  input  wire logic [IDX_W-1:0] i_cmp_b_addr,
  output logic      [IDX_W-1:0] o_cmp_b_data,
  output logic                  o_is_desc
);

  logic [IDX_W-1:0] r_perm [N];
  logic [N-1:0]     w_desc;

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst || i_load_id) begin
        r_perm[k] <= IDX_W'(k);
      end else if (i_swap_en && (i_swap_a == IDX_W'(k))) begin
        r_perm[k] <= r_perm[i_swap_b];
      end else if (i_swap_en && (i_swap_b == IDX_W'(k))) begin
        r_perm[k] <= r_perm[i_swap_a];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_desc
    assign w_desc[k] = (r_perm[k] == IDX_W'(desc_elem(N, k)));
  end

  assign o_rd_data    = r_perm[i_rd_addr];
  assign o_cmp_a_data = r_perm[i_cmp_a_addr];
  assign o_cmp_b_data = r_perm[i_cmp_b_addr];
  assign o_is_desc    = &w_desc;

endmodule

`default_nettype wire

// File: rtl/perm_engine.sv
// ============================================================================
// Module : perm_engine
// Brief  : Steps the held permutation to its lexicographic successor on
//          request. Optional build macro: PERM_CNT_EN (16-bit perm_cnt).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module perm_engine
  import perm_pkg::*;
#(
  parameter int N     = perm_pkg::N,
  parameter int IDX_W = perm_pkg::IDX_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
`ifdef PERM_CNT_EN
  output logic [CNT_W-1:0]      perm_cnt,
`endif
  perm_if.slave                 bus
);

  localparam logic [IDX_W-1:0] c_TOP   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] c_START = IDX_W'(N - 2);

  perm_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_i, r_j, r_pivot, r_lo, r_hi;
  logic [IDX_W-1:0] w_i_nxt, w_j_nxt, w_pivot_nxt, w_lo_nxt, w_hi_nxt;
  logic [IDX_W-1:0] w_cmp_a_addr, w_cmp_b_addr, w_cmp_a, w_cmp_b;
  logic [IDX_W-1:0] w_swap_a, w_swap_b;
  logic             w_swap_en, w_load_id, w_is_desc;
  logic             r_last;

  perm_regfile #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .i_load_id    (w_load_id),
    .i_swap_en    (w_swap_en),
    .i_swap_a     (w_swap_a),
    .i_swap_b     (w_swap_b),
    .i_rd_addr    (bus.W),
    .o_rd_data    (bus.perm_val),
    .i_cmp_a_addr (w_cmp_a_addr),
    .o_cmp_a_data (w_cmp_a),
    .i_cmp_b_addr (w_cmp_b_addr),
    .o_cmp_b_data (w_cmp_b),
    .o_is_desc    (w_is_desc)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_i_nxt      = r_i;
    w_j_nxt      = r_j;
    w_pivot_nxt  = r_pivot;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_cmp_a_addr = r_i;
    w_cmp_b_addr = r_i + 1'b1;
    w_swap_en    = 1'b0;
    w_swap_a     = r_lo;
    w_swap_b     = r_hi;
    w_load_id    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.step) begin
          w_state_nxt = ST_FIND_PIVOT;
          w_i_nxt     = c_START;
        end
      end
      ST_FIND_PIVOT: begin
        if (w_cmp_a < w_cmp_b) begin
          w_pivot_nxt = r_i;
          w_j_nxt     = c_TOP;
          w_state_nxt = ST_FIND_SUCC;
        end else if (r_i == '0) begin
          w_state_nxt = ST_WRAP;
        end else begin
          w_i_nxt = r_i - 1'b1;
        end
      end
      ST_FIND_SUCC: begin
        // Scanning down from the top guarantees the smallest larger successor.
        w_cmp_a_addr = r_j;
        w_cmp_b_addr = r_pivot;
        if (w_cmp_a > w_cmp_b) begin
          w_state_nxt = ST_SWAP;
        end else begin
          w_j_nxt = r_j - 1'b1;
        end
      end
      ST_SWAP: begin
        w_swap_en   = 1'b1;
        w_swap_a    = r_pivot;
        w_swap_b    = r_j;
        w_lo_nxt    = r_pivot + 1'b1;
        w_hi_nxt    = c_TOP;
        w_state_nxt = ST_REVERSE;
      end
      ST_REVERSE: begin
        if (r_lo < r_hi) begin
          w_swap_en = 1'b1;
          w_lo_nxt  = r_lo + 1'b1;
          w_hi_nxt  = r_hi - 1'b1;
        end else begin
          w_state_nxt = ST_VALID;
        end
      end
      ST_WRAP: begin
        w_load_id   = 1'b1;
        w_state_nxt = ST_VALID;
      end
      ST_VALID: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_pivot <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_pivot <= w_pivot_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      if (r_state == ST_VALID) begin
        r_last <= w_is_desc;
      end
    end
  end

  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.permute_valid = (r_state == ST_VALID);
  assign bus.last          = r_last;

`ifdef PERM_CNT_EN
  logic [CNT_W-1:0] r_perm_cnt;
  logic             r_after_wrap;

  // The cycle before VALID tells whether this step wrapped back to identity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perm_cnt   <= '0;
      r_after_wrap <= 1'b0;
    end else begin
      r_after_wrap <= (r_state == ST_WRAP);
      if (r_state == ST_VALID) begin
        r_perm_cnt <= r_after_wrap ? '0 : r_perm_cnt + 1'b1;
      end
    end
  end

  assign perm_cnt = r_perm_cnt;
`endif

endmodule

`default_nettype wire
